countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 22 ++
 rtl/tick_divider.sv | 30 +++
 rtl/countdown_timer.sv | 122 ++++++++++++
 tb/tb_countdown_timer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer: FSM encoding, field widths
// and a helper that folds minutes/seconds into a total-seconds count.
package countdown_timer_pkg;

   localparam int unsigned SECONDS_MAX = 59;
   localparam int unsigned TIMER_W     = 11;
   localparam int unsigned MIN_W       = 5;
   localparam int unsigned SEC_W       = 6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   function automatic logic [TIMER_W-1:0] to_total(input logic [MIN_W-1:0] m,
                                                   input logic [SEC_W-1:0] s);
      return TIMER_W'(m) * TIMER_W'(60) + TIMER_W'(s);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// One-second prescaler: counts enabled cycles and strobes tick_c on the last one,
// wrapping to zero on that same edge. Holding enable low preserves a partial second.
module tick_divider #(
   parameter int unsigned CLKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick_c
);

   localparam int unsigned CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_SEC - 1);

   logic [CNT_W-1:0] count;

   assign tick_c = enable && (count == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick_c) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with pause, warning window and expiry strobe.
// All outputs are registered from the next-state values so they stay mutually consistent.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned CLKS_PER_SEC = 50_000_000,
   parameter int unsigned WARN_SECONDS = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [MIN_W-1:0]   load_minutes,
   input  logic [SEC_W-1:0]   load_seconds,
   input  logic               playing_condition,
   output logic [TIMER_W-1:0] timer,
   output logic [SEC_W-1:0]   seconds,
   output logic [MIN_W-1:0]   minutes,
   output logic               running,
   output logic               warning,
   output logic               expired,
   output logic               expire_pulse
);

   state_t             state, state_next;
   logic [TIMER_W-1:0] timer_next;
   logic [SEC_W-1:0]   seconds_next;
   logic [MIN_W-1:0]   minutes_next;
   logic [SEC_W-1:0]   load_sec_c;
   logic               expire_pulse_next;
   logic               warning_next;
   logic               count_en_c;
   logic               tick_c;

   assign count_en_c = (state == ST_RUNNING);

   tick_divider #(
      .CLKS_PER_SEC(CLKS_PER_SEC)
   ) u_tick_divider (
      .clk    (clk),
      .reset  (reset),
      .enable (count_en_c),
      .clear  (load),
      .tick_c (tick_c)
   );

   // Next-state and next-count logic; load overrides any coincident tick.
   always_comb begin
      state_next        = state;
      timer_next        = timer;
      seconds_next      = seconds;
      minutes_next      = minutes;
      expire_pulse_next = 1'b0;
      load_sec_c        = (load_seconds > SEC_W'(SECONDS_MAX)) ? SEC_W'(SECONDS_MAX) : load_seconds;

      if (load) begin
         minutes_next = load_minutes;
         seconds_next = load_sec_c;
         timer_next   = to_total(load_minutes, load_sec_c);
         if (timer_next == '0) begin
            state_next = ST_EXPIRED;
         end else if (playing_condition) begin
            state_next = ST_RUNNING;
         end else begin
            state_next = ST_PAUSED;
         end
      end else begin
         unique case (state)
            ST_RUNNING: begin
               if (!playing_condition) begin
                  state_next = ST_PAUSED;
               end
               if (tick_c) begin
                  timer_next = timer - TIMER_W'(1);
                  if (seconds != '0) begin
                     seconds_next = seconds - SEC_W'(1);
                  end else begin
                     seconds_next = SEC_W'(SECONDS_MAX);
                     minutes_next = minutes - MIN_W'(1);
                  end
                  if (timer == TIMER_W'(1)) begin
                     state_next        = ST_EXPIRED;
                     expire_pulse_next = 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (playing_condition) begin
                  state_next = ST_RUNNING;
               end
            end
            default: begin
            end
         endcase
      end

      warning_next = (state_next == ST_RUNNING) && (timer_next != '0) &&
                     (32'(timer_next) <= WARN_SECONDS);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         timer        <= '0;
         seconds      <= '0;
         minutes      <= '0;
         running      <= 1'b0;
         warning      <= 1'b0;
         expired      <= 1'b0;
         expire_pulse <= 1'b0;
      end else begin
         state        <= state_next;
         timer        <= timer_next;
         seconds      <= seconds_next;
         minutes      <= minutes_next;
         running      <= (state_next == ST_RUNNING);
         warning      <= warning_next;
         expired      <= (state_next == ST_EXPIRED);
         expire_pulse <= expire_pulse_next;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a total-seconds reference model.
module tb_countdown_timer;

   localparam int CPS  = 4;
   localparam int WARN = 3;

   logic        clk;
   logic        reset;
   logic        load;
   logic [4:0]  load_minutes;
   logic [5:0]  load_seconds;
   logic        playing_condition;
   logic [10:0] timer;
   logic [5:0]  seconds;
   logic [4:0]  minutes;
   logic        running;
   logic        warning;
   logic        expired;
   logic        expire_pulse;

   int checks     = 0;
   int failures   = 0;
   int pulse_seen = 0;
   bit cmp_en     = 0;

   // Reference model: remaining seconds, cycles spent counting in the current second.
   int m_rem      = 0;
   int m_frac     = 0;
   bit m_live     = 0;
   bit m_counting = 0;
   bit m_done     = 0;
   bit m_pulse    = 0;
   int m_s;

   countdown_timer #(
      .CLKS_PER_SEC(CPS),
      .WARN_SECONDS(WARN)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .load              (load),
      .load_minutes      (load_minutes),
      .load_seconds      (load_seconds),
      .playing_condition (playing_condition),
      .timer             (timer),
      .seconds           (seconds),
      .minutes           (minutes),
      .running           (running),
      .warning           (warning),
      .expired           (expired),
      .expire_pulse      (expire_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      m_pulse = 1'b0;
      if (reset) begin
         m_rem = 0; m_frac = 0; m_live = 0; m_counting = 0; m_done = 0;
      end else if (load) begin
         m_s        = (int'(load_seconds) > 59) ? 59 : int'(load_seconds);
         m_rem      = int'(load_minutes) * 60 + m_s;
         m_frac     = 0;
         m_live     = (m_rem != 0);
         m_done     = (m_rem == 0);
         m_counting = m_live && playing_condition;
      end else if (m_live) begin
         if (m_counting) begin
            m_frac++;
            if (m_frac == CPS) begin
               m_frac = 0;
               m_rem--;
               if (m_rem == 0) begin
                  m_pulse = 1'b1; m_done = 1'b1; m_live = 1'b0; m_counting = 1'b0;
               end
            end
         end
         if (m_live) m_counting = playing_condition;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("timer",        32'(timer),        32'(m_rem));
         check("seconds",      32'(seconds),      32'(m_rem % 60));
         check("minutes",      32'(minutes),      32'(m_rem / 60));
         check("running",      32'(running),      32'(m_counting));
         check("warning",      32'(warning),      32'(m_counting && m_rem > 0 && m_rem <= WARN));
         check("expired",      32'(expired),      32'(m_done));
         check("expire_pulse", 32'(expire_pulse), 32'(m_pulse));
         if (expire_pulse === 1'b1) pulse_seen++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input int m, input int s, input bit p);
      load              = 1'b1;
      load_minutes      = 5'(m);
      load_seconds      = 6'(s);
      playing_condition = p;
   endtask

   initial begin
      int p0;
      reset = 1'b1; load = 1'b0; load_minutes = '0; load_seconds = '0; playing_condition = 1'b0;
      step(2);
      cmp_en = 1'b1;
      check("rst_timer",   32'(timer),   0);
      check("rst_running", 32'(running), 0);
      check("rst_expired", 32'(expired), 0);
      check("rst_pulse",   32'(expire_pulse), 0);
      reset = 1'b0;

      // 0:05 counting to expiry
      p0 = pulse_seen;
      do_load(0, 5, 1'b1); step(1); load = 1'b0;
      check("s1_timer5", 32'(timer), 5);
      check("s1_run",    32'(running), 1);
      for (int k = 4; k >= 0; k--) begin
         step(4);
         check("s1_timer",   32'(timer),        32'(k));
         check("s1_warning", 32'(warning),      32'(k >= 1 && k <= 3));
         check("s1_pulse",   32'(expire_pulse), 32'(k == 0));
      end
      step(1);
      check("s1_pulse_off", 32'(expire_pulse), 0);
      check("s1_expired",   32'(expired), 1);
      step(8);
      check("s1_hold",      32'(timer), 0);
      check("s1_pulses",    32'(pulse_seen - p0), 1);

      // 1:00 borrows into seconds
      do_load(1, 0, 1'b1); step(1); load = 1'b0;
      step(4);
      check("s2_sec",   32'(seconds), 59);
      check("s2_min",   32'(minutes), 0);
      check("s2_timer", 32'(timer),   59);

      // pause preserves the partial second
      do_load(0, 2, 1'b1); step(1); load = 1'b0;
      step(1); playing_condition = 1'b0;
      step(3);
      check("s3_paused", 32'(running), 0);
      check("s3_timer",  32'(timer),   2);
      step(7); playing_condition = 1'b1;
      step(1);
      check("s3_resume", 32'(running), 1);
      step(1);
      check("s3_not_yet", 32'(timer), 2);
      step(1);
      check("s3_dec",     32'(timer), 1);

      // load coincident with a tick wins and restarts the second
      do_load(0, 20, 1'b1); step(1); load = 1'b0;
      step(3); do_load(0, 9, 1'b1);
      step(1); load = 1'b0;
      check("s4_timer", 32'(timer),   9);
      check("s4_sec",   32'(seconds), 9);
      step(3);
      check("s4_wait",  32'(timer), 9);
      step(1);
      check("s4_dec",   32'(timer), 8);

      // zero load, reload, clamp
      p0 = pulse_seen;
      do_load(0, 0, 1'b1); step(1);
      check("s5_expired", 32'(expired), 1);
      check("s5_nopulse", 32'(expire_pulse), 0);
      do_load(0, 45, 1'b0); step(1);
      check("s5_sec45",   32'(seconds), 45);
      check("s5_paused",  32'(running), 0);
      do_load(2, 63, 1'b0); step(1); load = 1'b0;
      check("s5_clamp",   32'(seconds), 59);
      check("s5_total",   32'(timer),   179);
      check("s5_pulses",  32'(pulse_seen - p0), 0);

      // reset one second before expiry
      p0 = pulse_seen;
      do_load(0, 2, 1'b1); step(1); load = 1'b0;
      step(4);
      check("s6_timer1", 32'(timer),   1);
      check("s6_warn",   32'(warning), 1);
      step(2); reset = 1'b1;
      step(1);
      check("s6_timer",   32'(timer),   0);
      check("s6_running", 32'(running), 0);
      check("s6_warning", 32'(warning), 0);
      check("s6_expired", 32'(expired), 0);
      step(1); reset = 1'b0;
      step(6);
      check("s6_idle",    32'(timer),   0);
      check("s6_idlerun", 32'(running), 0);
      check("s6_pulses",  32'(pulse_seen - p0), 0);

      // randomized traffic checked by the model every cycle
      for (int i = 0; i < 6000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         load  = ($urandom_range(0, 59) == 0);
         if (load) begin
            load_minutes = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                       : 5'($urandom_range(0, 1));
            load_seconds = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 8))
                                                       : 6'($urandom_range(0, 63));
         end
         if ($urandom_range(0, 7) == 0) playing_condition = ~playing_condition;
         step(1);
      end
      reset = 1'b0; load = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
